// File: rtl/calc_pkg.sv
// Shared calculator definitions: datapath widths, arbiter state encoding and
// the ALU8 opcode map used by every block that talks to the ALU.
package calc_pkg;

    localparam int WIDTH = 8;
    localparam int OPW   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EXEC    = 2'b01,
        ST_RELEASE = 2'b10
    } arb_state_e;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_PASSA = 4'b0101;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    assign valid  = req0 | req1;
    assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/alu8_arbiter.sv
// Shares one ALU8 between the front-panel sequencer (port 0) and the
// diagnostic engine (port 1); operands latched at grant, result one cycle later.
//
// Handshake: a requester holds reqN high; gntN rises on the edge it wins and
// stays high until reqN is sampled low after doneN; doneN is a one-cycle pulse
// marking result/flags valid. Operands are only sampled on the granting edge.
module alu8_arbiter
    import calc_pkg::*;
#(
    parameter int WIDTH = calc_pkg::WIDTH,
    parameter int OPW   = calc_pkg::OPW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [OPW-1:0]   op0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output arb_state_e       state_o
);

    arb_state_e       state_q;
    logic             last_q, g_q;
    logic             gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
    logic [WIDTH-1:0] result_q, alu_a_q, alu_b_q;
    logic [OPW-1:0]   alu_op_q;
    logic             zero_q, carry_q, overflow_q;

    logic pick_valid, pick_winner, owner_req;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign owner_req = g_q ? req1 : req0;

    always_ff @(posedge clock) begin
        if (reset || (state_q != ST_IDLE && state_q != ST_EXEC && state_q != ST_RELEASE)) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            g_q        <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        alu_a_q  <= pick_winner ? a1  : a0;
                        alu_b_q  <= pick_winner ? b1  : b0;
                        alu_op_q <= pick_winner ? op1 : op0;
                        g_q      <= pick_winner;
                        gnt0_q   <= ~pick_winner;
                        gnt1_q   <= pick_winner;
                        busy_q   <= 1'b1;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q   <= alu_result;
                    zero_q     <= alu_zero;
                    carry_q    <= alu_carry;
                    overflow_q <= alu_overflow;
                    done0_q    <= ~g_q;
                    done1_q    <= g_q;
                    last_q     <= g_q;
                    state_q    <= ST_RELEASE;
                end
                default: begin
                    // RELEASE: grant is held until the owner lets go of its request
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    if (!owner_req) begin
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign busy     = busy_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_alu8_arbiter.sv
// Bench for alu8_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of arbitration and ALU arithmetic.
module tb_alu8_arbiter;
    import calc_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rq = '0;
    logic [7:0] ra [2];
    logic [7:0] rb [2];
    logic [3:0] rop [2];
    logic       gnt0, gnt1, done0, done1, zero, carry, overflow, busy;
    logic [7:0] result, alu_a, alu_b, alu_result;
    logic [3:0] alu_op;
    logic       alu_zero, alu_carry, alu_overflow;
    arb_state_e state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int          owner = -1;
    int          age   = 0;
    bit          e_last = 1'b1;
    logic [1:0]  e_gnt = '0, e_done = '0;
    logic        e_busy = 1'b0;
    logic [10:0] e_out = '0;
    logic [7:0]  e_alu_a = '0, e_alu_b = '0;
    logic [3:0]  e_alu_op = '0;
    logic [10:0] exp_q[$];
    bit   [1:0]  got = '0;

    always #5 clock = ~clock;

    // ALU8 behaviour: {overflow, carry, zero, result}
    function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            ALU_SUB: begin
                s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            default: r = a;
        endcase
        return {v, c, (r == 8'd0), r};
    endfunction

    assign {alu_overflow, alu_carry, alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_op);

    alu8_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(rq[0]), .a0(ra[0]), .b0(rb[0]), .op0(rop[0]),
        .req1(rq[1]), .a1(ra[1]), .b1(rb[1]), .op1(rop[1]),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .zero(zero), .carry(carry), .overflow(overflow),
        .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .state_o(state_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got_v, exp_v, $time);
        end
    endtask

    // Advance the model by one edge using the inputs about to be sampled.
    task automatic model_edge();
        int w;
        if (reset) begin
            owner = -1; age = 0; e_last = 1'b1; e_gnt = '0; e_done = '0; e_busy = 1'b0;
            e_out = '0; e_alu_a = '0; e_alu_b = '0; e_alu_op = '0;
            exp_q.delete();
        end else if (owner < 0) begin
            e_done = '0;
            if (rq != 2'b00) begin
                w = (rq == 2'b11) ? (e_last ? 0 : 1) : (rq[1] ? 1 : 0);
                owner = w; age = 0;
                e_gnt = '0; e_gnt[w] = 1'b1; e_busy = 1'b1;
                e_alu_a = ra[w]; e_alu_b = rb[w]; e_alu_op = rop[w];
                exp_q.push_back(alu_f(ra[w], rb[w], rop[w]));
            end
        end else begin
            age++;
            if (age == 1) begin
                e_done = '0; e_done[owner] = 1'b1;
                e_out = exp_q.pop_front();
                e_last = (owner == 1);
            end else begin
                e_done = '0;
                if (!rq[owner]) begin
                    e_gnt = '0; e_busy = 1'b0; owner = -1;
                end
            end
        end
    endtask

    task automatic compare();
        arb_state_e e_st;
        e_st = (owner < 0) ? ST_IDLE : ((age == 0) ? ST_EXEC : ST_RELEASE);
        check_eq("gnt",    {30'd0, gnt1, gnt0}, {30'd0, e_gnt});
        check_eq("done",   {30'd0, done1, done0}, {30'd0, e_done});
        check_eq("busy",   {31'd0, busy}, {31'd0, e_busy});
        check_eq("result_flags", {21'd0, overflow, carry, zero, result}, {21'd0, e_out});
        check_eq("alu_ops", {12'd0, alu_op, alu_b, alu_a}, {12'd0, e_alu_op, e_alu_b, e_alu_a});
        check_eq("state",  {30'd0, state_o}, {30'd0, e_st});
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic set_req(input int p, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        rq[p] = 1'b1; ra[p] = a; rb[p] = b; rop[p] = op;
    endtask

    task automatic wait_done(input int p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if ((p == 1) ? done1 : done0) seen = 1'b1;
        end
        check_eq("wait_done", {31'd0, seen}, 32'd1);
    endtask

    task automatic rand_req(input int p);
        set_req(p, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 6)));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        for (int p = 0; p < 2; p++) begin ra[p] = '0; rb[p] = '0; rop[p] = '0; end
        do_reset();
        check_eq("reset_outputs", {19'd0, gnt0, gnt1, done0, done1, busy, result, zero},
                 32'd0);
        step();

        // single request on port 0
        set_req(0, 8'd100, 8'd27, ALU_ADD);
        wait_done(0);
        check_eq("t1_result", {24'd0, result}, 32'd127);
        check_eq("t1_zc", {30'd0, zero, carry}, 32'd0);
        rq[0] = 1'b0;
        step();
        check_eq("t1_busy_low", {31'd0, busy}, 32'd0);
        step();

        // simultaneous requests after reset: port 0 first, port 1 kept pending
        do_reset();
        rand_req(0); rand_req(1);
        step();
        check_eq("t2_first_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        wait_done(0);
        rq[0] = 1'b0;
        wait_done(1);
        rq[1] = 1'b0;
        step();
        rand_req(0); rand_req(1);
        step();
        check_eq("t2_regrant_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        wait_done(0);
        rq[0] = 1'b0;
        wait_done(1);
        rq[1] = 1'b0;
        step();

        // port 1 carry and zero cases
        set_req(1, 8'd200, 8'd100, ALU_ADD);
        wait_done(1);
        check_eq("t3_add", {23'd0, carry, result}, {23'd0, 1'b1, 8'd44});
        rq[1] = 1'b0;
        step();
        set_req(1, 8'd5, 8'd5, ALU_SUB);
        wait_done(1);
        check_eq("t3_sub", {23'd0, zero, result}, {23'd0, 1'b1, 8'd0});
        rq[1] = 1'b0;
        step();

        // operand change after grant is ignored
        set_req(0, 8'd10, 8'd5, ALU_ADD);
        step();
        ra[0] = 8'd99;
        wait_done(0);
        check_eq("t4_captured", {24'd0, result}, 32'd15);
        rq[0] = 1'b0;
        step();

        // reset during EXEC
        set_req(0, 8'd3, 8'd4, ALU_ADD);
        step();
        reset = 1'b1;
        step();
        check_eq("t5_abort", {18'd0, state_o, gnt0, gnt1, done0, done1, busy, result},
                 32'd0);
        reset = 1'b0;
        rand_req(1);
        step();
        check_eq("t5_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        wait_done(0);
        rq[0] = 1'b0;
        wait_done(1);
        rq[1] = 1'b0;
        step();

        // long hold on port 0 starves port 1
        rand_req(0);
        step();
        rand_req(1);
        wait_done(0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done0) cnt++;
        end
        check_eq("t6_extra_done0", cnt, 32'd0);
        check_eq("t6_hold", {30'd0, gnt1, gnt0}, 32'd1);
        rq[0] = 1'b0;
        wait_done(1);
        rq[1] = 1'b0;
        step();

        // random traffic
        got = '0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq[p]) begin
                    if ($urandom_range(0, 3) == 0) begin rand_req(p); got[p] = 1'b0; end
                end else if (got[p] && $urandom_range(0, 2) == 0) begin
                    rq[p] = 1'b0;
                end
                if ($urandom_range(0, 4) == 0) begin
                    ra[p] = 8'($urandom); rb[p] = 8'($urandom);
                end
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
            for (int p = 0; p < 2; p++) if (e_gnt[p]) got[p] = 1'b1;
        end
        reset = 1'b0;
        rq = '0;
        for (int i = 0; i < 5; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
